// File: rtl/tts_pkg.sv
// rtl/tts_pkg.sv - shared types and constants for the truth table sweeper
//
// Purpose: sweeper FSM state encoding, default widths and the reference
//          minterm mask of the function unit the sweeper sits beside.
// Ports:   none (package).
package tts_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int N_IN_DEF   = 3;
  localparam int MASK_W_DEF = 1 << N_IN_DEF;

  // Minterms 0, 2, 4, 6, 7 of the unit's primary output e.
  localparam logic [MASK_W_DEF-1:0] EXP_02467 = 8'hD5;

endpackage

// File: rtl/truth_table_sweeper_counter.sv
// rtl/truth_table_sweeper_counter.sv - code index and per-code settle down-counter
//
// Purpose: holds the input code currently driven to the function unit and
//          the number of settle cycles still to wait for that code.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   load          start a sweep: index 0, settle counter reloaded
//   advance       move to the next code, settle counter reloaded
//   dec           one settle cycle elapsed
//   index         current code
//   last_code     index is the final code of the sweep
//   settle_zero   settle counter has reached 0 (sample next)
module sweep_counter
  import tts_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            advance,
  input  logic            dec,
  output logic [N_IN-1:0] index,
  output logic            last_code,
  output logic            settle_zero
);

  // Keep at least one bit so SETTLE == 1 still elaborates.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST   = '1;

  logic [CW-1:0] settle_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index      <= '0;
      settle_cnt <= '0;
    end else if (load) begin
      index      <= '0;
      settle_cnt <= RELOAD;
    end else if (advance) begin
      index      <= index + N_IN'(1);
      settle_cnt <= RELOAD;
    end else if (dec) begin
      settle_cnt <= settle_cnt - CW'(1);
    end
  end

  assign last_code   = (index == LAST);
  assign settle_zero = (settle_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep and self-check of a 3-input unit
//
// Purpose: drives every input code into the function unit, samples its
//          primary and gated outputs, builds the measured minterm mask and
//          compares it with an expected mask.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   start            request a sweep (accepted only in idle)
//   abort            cancel a running sweep
//   expected         expected minterm mask, bit i = f(code i)
//   fn_in, fn_en     code and AND-gate enable driven to the unit
//   fn_out, fn_gated unit primary output e and gated output f = e & d
//   busy, done       sweep in progress / one-cycle completion pulse
//   pass             last sweep completed with no mismatch
//   mask             measured minterm mask
//   mismatch_cnt     number of mismatching codes
//   first_bad(_valid) lowest mismatching code and its qualifier
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 2,
  localparam int MASK_W = 1 << N_IN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [MASK_W-1:0] expected,
  output logic [N_IN-1:0]   fn_in,
  output logic              fn_en,
  input  logic              fn_out,
  input  logic              fn_gated,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MASK_W-1:0] mask,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_bad,
  output logic              first_bad_valid
);

  localparam int CNT_W = N_IN + 1;

  state_t            state;
  logic [MASK_W-1:0] exp_q;
  logic [N_IN-1:0]   index;
  logic              last_code;
  logic              settle_zero;

  logic              sweeping;
  logic              accept;
  logic              code_bad;
  logic [CNT_W-1:0]  cnt_next;

  assign sweeping = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign accept   = (state == ST_IDLE) && start && !abort;

  // A code is bad if e disagrees with the expectation, or if the gate
  // output does not follow e while the enable is held high.
  assign code_bad = (fn_out != exp_q[index]) || (fn_gated != fn_out);
  assign cnt_next = mismatch_cnt + CNT_W'(code_bad);

  sweep_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_counter (
    .clock       (clock),
    .reset       (reset),
    .load        (accept),
    .advance     ((state == ST_SAMPLE) && !abort && !last_code),
    .dec         ((state == ST_SETTLE) && !abort && !settle_zero),
    .index       (index),
    .last_code   (last_code),
    .settle_zero (settle_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      exp_q           <= '0;
      busy            <= 1'b0;
      pass            <= 1'b0;
      mask            <= '0;
      mismatch_cnt    <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            exp_q           <= expected;
            mask            <= '0;
            mismatch_cnt    <= '0;
            pass            <= 1'b0;
            first_bad       <= '0;
            first_bad_valid <= 1'b0;
            busy            <= 1'b1;
            state           <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else if (settle_zero) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // Abort discards this cycle's sample; earlier samples remain.
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            mask[index]  <= fn_out;
            mismatch_cnt <= cnt_next;
            if (code_bad && !first_bad_valid) begin
              first_bad       <= index;
              first_bad_valid <= 1'b1;
            end
            if (last_code) begin
              // Verdict uses the count including this final code so it is
              // visible together with the done pulse.
              busy  <= 1'b0;
              pass  <= (cnt_next == '0);
              state <= ST_DONE;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    fn_in = '0;
    fn_en = 1'b0;
    if (sweeping) begin
      fn_in = index;
      fn_en = 1'b1;
    end
  end

  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic [2:0] fn_in;
  logic       fn_en;
  logic       fn_out;
  logic       fn_gated;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] mask;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_bad;
  logic       first_bad_valid;

  // Behavioural minterm-(0,2,4,6,7) unit with f = e & d.
  logic [7:0] unit_tt;
  logic       gate_fault;
  assign fn_out   = unit_tt[fn_in];
  assign fn_gated = gate_fault ? 1'b0 : (fn_out & fn_en);

  truth_table_sweeper dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .expected        (expected),
    .fn_in           (fn_in),
    .fn_en           (fn_en),
    .fn_out          (fn_out),
    .fn_gated        (fn_gated),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .mask            (mask),
    .mismatch_cnt    (mismatch_cnt),
    .first_bad       (first_bad),
    .first_bad_valid (first_bad_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests;
  int fails;

  typedef struct {
    logic [7:0] expected;
    logic       gate_fault;
    logic [7:0] mask;
    logic [3:0] cnt;
    logic [2:0] first_bad;
    logic       fbv;
    logic       pass;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts a sweep and waits for done; cyc = edges from the accepting edge.
  task automatic run_sweep(input logic [7:0] exp_v, output int cyc);
    expected = exp_v;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " mask"}, mask, 0);
    chk({tag, " cnt"}, mismatch_cnt, 0);
    chk({tag, " first_bad"}, first_bad, 0);
    chk({tag, " fbv"}, first_bad_valid, 0);
    chk({tag, " fn_in"}, fn_in, 0);
    chk({tag, " fn_en"}, fn_en, 0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    int busy_seen;

    tests = 0;
    fails = 0;
    unit_tt = 8'hD5;
    gate_fault = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    expected = 8'h00;

    vecs[0] = '{8'hD5, 1'b0, 8'hD5, 4'd0, 3'd0, 1'b0, 1'b1};
    vecs[1] = '{8'h55, 1'b0, 8'hD5, 4'd1, 3'd7, 1'b1, 1'b0};
    vecs[2] = '{8'hD5, 1'b1, 8'hD5, 4'd5, 3'd0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 8'hD5, 4'd3, 3'd1, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 8'hD5, 4'd5, 3'd0, 1'b1, 1'b0};

    step();
    step();
    chk_outputs_zero("reset");
    reset = 1'b0;
    step();

    // Golden sweep with per-cycle drive check.
    expected = 8'hD5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("golden fn_in k=%0d", k), fn_in, k / 3);
      chk($sformatf("golden fn_en k=%0d", k), fn_en, 1);
      chk($sformatf("golden done k=%0d", k), done, 0);
      chk($sformatf("golden busy k=%0d", k), busy, 1);
      step();
    end
    chk("golden done at 24", done, 1);
    chk("golden busy at done", busy, 0);
    chk("golden fn_en at done", fn_en, 0);
    chk("golden fn_in at done", fn_in, 0);
    chk("golden pass", pass, 1);
    chk("golden mask", mask, 8'hD5);
    chk("golden cnt", mismatch_cnt, 0);
    chk("golden fbv", first_bad_valid, 0);
    step();
    chk("golden done one cycle", done, 0);
    chk("golden pass held", pass, 1);

    // Table-driven sweeps.
    for (int i = 0; i < 5; i++) begin
      gate_fault = vecs[i].gate_fault;
      run_sweep(vecs[i].expected, cyc);
      chk($sformatf("vec%0d latency", i), cyc, 24);
      chk($sformatf("vec%0d mask", i), mask, vecs[i].mask);
      chk($sformatf("vec%0d cnt", i), mismatch_cnt, vecs[i].cnt);
      chk($sformatf("vec%0d first_bad", i), first_bad, vecs[i].first_bad);
      chk($sformatf("vec%0d fbv", i), first_bad_valid, vecs[i].fbv);
      chk($sformatf("vec%0d pass", i), pass, vecs[i].pass);
      gate_fault = 1'b0;
      step();
    end

    // Start while busy is ignored.
    expected = 8'hD5;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 10) start = 1'b1;
      step();
      start = 1'b0;
      cyc++;
    end
    chk("busy-start latency", cyc, 24);
    chk("busy-start pass", pass, 1);
    chk("busy-start mask", mask, 8'hD5);
    done_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("busy-start no second done", done_seen, 0);
    chk("busy-start no second sweep", busy_seen, 0);
    chk("busy-start results held", mask, 8'hD5);

    // start and abort together in idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort idle busy", busy, 0);
    chk("start+abort idle pass held", pass, 1);

    // Abort in the settle phase of code 3.
    expected = 8'hD5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("abort pre fn_in", fn_in, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort fn_en", fn_en, 0);
    chk("abort fn_in", fn_in, 0);
    chk("abort pass", pass, 0);
    chk("abort done", done, 0);
    chk("abort mask low", mask[2:0], 3'b101);
    chk("abort mask high", mask[7:3], 0);
    chk("abort cnt", mismatch_cnt, 0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) done_seen++;
    end
    chk("abort no done", done_seen, 0);

    // Asynchronous reset mid-sweep at code 4.
    expected = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("midreset pre fn_in", fn_in, 4);
    chk("midreset pre mask", mask, 8'h05);
    #2;
    reset = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    step();
    reset = 1'b0;
    step();
    run_sweep(8'hD5, cyc);
    chk("post-reset latency", cyc, 24);
    chk("post-reset mask", mask, 8'hD5);
    chk("post-reset pass", pass, 1);
    chk("post-reset cnt", mismatch_cnt, 0);
    chk("post-reset fbv", first_bad_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives a 3-input combinational function unit (the UDP-based minterm circuit and its enable-gated AND output) through all 2^N_IN input codes.
- Samples the unit's output for each code, assembles the measured minterm mask and compares it against an expected mask.
- Reports pass/fail, mismatch count and first failing code.
- Sits beside the function unit as its on-chip controller and self-checker.

Parameters:
- N_IN, 3: function input width; MASK_W = 2^N_IN (8).
- SETTLE, 2: cycles each code is held before sampling; must be >= 1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a sweep; honoured only in IDLE
- abort  in  1  synchronous sweep cancel
- expected  in  MASK_W  expected minterm mask; bit i = f(code i)
- fn_in  out  N_IN  code driven to the unit (MSB = A, LSB = C)
- fn_en  out  1  drives the unit's D input (AND gate enable)
- fn_out  in  1  unit primary output (e)
- fn_gated  in  1  unit gated output (f = e & d)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  last sweep matched fully
- mask  out  MASK_W  measured minterm mask
- mismatch_cnt  out  N_IN+1  number of mismatching codes
- first_bad  out  N_IN  lowest mismatching code
- first_bad_valid  out  1  first_bad is meaningful

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, index 0, settle counter 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge latches expected into exp_q.
  - Clears mask, mismatch_cnt, pass, first_bad, first_bad_valid.
  - Sets index=0, busy=1, goes to SETTLE.
- SETTLE:
  - fn_in=index, fn_en=1, held for SETTLE cycles (counter SETTLE-1 down to 0), then SAMPLE.
- SAMPLE (one cycle):
  - fn_in and fn_en unchanged.
  - At the edge, mask[index] <= fn_out.
  - A code mismatches if fn_out != exp_q[index] or fn_gated != fn_out (gate fault).
  - On mismatch, mismatch_cnt increments; if first_bad_valid=0, first_bad <= index and first_bad_valid <= 1.
  - index == MASK_W-1 goes to DONE; otherwise index+1 and back to SETTLE.
- DONE (one cycle):
  - done=1, busy=0, pass <= (final mismatch_cnt == 0), fn_en=0, fn_in=0.
  - Then IDLE.
- Timing: per code SETTLE+1 cycles. done is high in the cycle beginning MASK_W*(SETTLE+1) edges after the start-accepting edge (24 for defaults).
- Outside SETTLE/SAMPLE: fn_en=0, fn_in=0.
- Results (mask, pass, counts, first_bad) hold until the next accepted start.
- start while busy or in DONE is ignored; it is not queued.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE; no done pulse; pass=0, busy=0, fn_en=0.
  - Partial mask and count are retained.
  - abort has priority over the SAMPLE update in the same cycle.
  - abort in IDLE or DONE has no effect.
- start and abort both high in IDLE: abort wins, start is ignored.
- mismatch_cnt cannot overflow: its maximum is MASK_W, and the width is N_IN+1.
- All outputs are registered except fn_en, fn_in and done, which decode state and index.

Decomposition:
- Package tts_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - N_IN_DEF=3, MASK_W_DEF=8
  - EXP_02467 = 8'hD5 (minterms 0, 2, 4, 6, 7)
- Sub-module sweep_counter holds the index register plus the settle down-counter, with outputs last_code and settle_zero.
- The top level holds the FSM and result registers.

Test Plan:
- Bench: a behavioural model of the minterm-(0,2,4,6,7) unit with f = e & d is wired to fn_in/fn_en.
- Golden sweep: reset, expected=8'hD5, start -> fn_in steps 0..7 with 3 cycles each, fn_en=1 throughout; done at +24 cycles; mask=8'hD5, pass=1, mismatch_cnt=0, first_bad_valid=0.
- Single mismatch: expected=8'h55 -> mask=8'hD5, mismatch_cnt=1, first_bad=7, first_bad_valid=1, pass=0.
- Gate fault: force fn_gated=0 -> mismatch_cnt=5, first_bad=0, pass=0.
- Start while busy: pulse start again at cycle 10 -> single done at +24, no second sweep, results unchanged.
- Abort at index 3: abort in the SETTLE of code 3 -> IDLE next cycle; done never pulses; busy=0, pass=0, fn_en=0; mask bits 0..2 = 3'b101.
- Reset mid-sweep at index 4: assert reset asynchronously -> all outputs 0 immediately (before the next edge); a subsequent start gives the full golden result.
